// File: rtl/hood_pkg.sv
// Shared encodings for the range hood mode controller and the gear/timer block.
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_STANDBY = 3'b000,
    MODE_GEAR1   = 3'b001,
    MODE_GEAR2   = 3'b010,
    MODE_GEAR3   = 3'b011,
    MODE_OFF     = 3'b100,
    MODE_MENU    = 3'b101
  } mode_t;

  localparam logic RET_STANDBY = 1'b0;
  localparam logic RET_GEAR2   = 1'b1;

  // Counter width wide enough for either limit, never narrower than 4 bits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m + 1);
    return (w > 4) ? w : 4;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one debounced button level; history resets to 1
// so a button held through reset does not register a press.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range hood mode controller: power, menu, gear selection and hurricane handshake.
// Optional build macro LONG_PRESS_POWER_EN: power toggles only after a long hold.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int MENU_TIMEOUT_S = 10,
  parameter int LONG_PRESS_S   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       power_btn,
  input  logic       menu_btn,
  input  logic       gear1_btn,
  input  logic       gear2_btn,
  input  logic       gear3_btn,
  input  logic       hurricane_avail,
  input  logic       hurricane_done,
  input  logic       return_state,
  output logic [2:0] mode_state,
  output logic       power_on,
  output logic       menu_active,
  output logic       hurricane_req
);

  localparam int CNT_W = cnt_width(MENU_TIMEOUT_S, LONG_PRESS_S);

  mode_t            state, next_state;
  logic [CNT_W-1:0] idle_cnt;
  logic             power_press, menu_press, gear1_press, gear2_press, gear3_press;
  logic             any_press, power_evt, menu_timeout;

  btn_edge_detect u_power (.clk(clk), .rst(rst), .level(power_btn), .press(power_press));
  btn_edge_detect u_menu  (.clk(clk), .rst(rst), .level(menu_btn),  .press(menu_press));
  btn_edge_detect u_gear1 (.clk(clk), .rst(rst), .level(gear1_btn), .press(gear1_press));
  btn_edge_detect u_gear2 (.clk(clk), .rst(rst), .level(gear2_btn), .press(gear2_press));
  btn_edge_detect u_gear3 (.clk(clk), .rst(rst), .level(gear3_btn), .press(gear3_press));

  assign any_press = power_press | menu_press | gear1_press | gear2_press | gear3_press;

`ifdef LONG_PRESS_POWER_EN
  // A hold only counts once it began with a real press; fired blocks repeats.
  logic             holding, fired;
  logic [CNT_W-1:0] hold_cnt;

  assign power_evt = holding & power_btn & tick_1hz & ~fired &
                     (hold_cnt == CNT_W'(LONG_PRESS_S - 1));

  always_ff @(posedge clk) begin
    if (rst || !power_btn) begin
      holding  <= 1'b0;
      fired    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (power_press) holding <= 1'b1;
      if (holding && tick_1hz && !fired) begin
        if (hold_cnt == CNT_W'(LONG_PRESS_S - 1)) fired <= 1'b1;
        else                                     hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign power_evt = power_press;
`endif

  assign menu_timeout = tick_1hz & ~any_press &
                        (idle_cnt >= CNT_W'(MENU_TIMEOUT_S - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= MODE_OFF;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    power_on    = 1'b1;
    menu_active = 1'b0;
    case (state)
      MODE_OFF: begin
        power_on = 1'b0;
        if (power_evt) next_state = MODE_STANDBY;
      end
      MODE_STANDBY: begin
        if (power_evt)       next_state = MODE_OFF;
        else if (menu_press) next_state = MODE_MENU;
      end
      MODE_MENU: begin
        menu_active = 1'b1;
        if (power_evt)                           next_state = MODE_OFF;
        else if (menu_press)                     next_state = MODE_STANDBY;
        else if (gear1_press)                    next_state = MODE_GEAR1;
        else if (gear2_press)                    next_state = MODE_GEAR2;
        else if (gear3_press && hurricane_avail) next_state = MODE_GEAR3;
        else if (menu_timeout)                   next_state = MODE_STANDBY;
      end
      MODE_GEAR1, MODE_GEAR2: begin
        if (power_evt)                           next_state = MODE_OFF;
        else if (menu_press)                     next_state = MODE_STANDBY;
        else if (gear1_press)                    next_state = MODE_GEAR1;
        else if (gear2_press)                    next_state = MODE_GEAR2;
        else if (gear3_press && hurricane_avail) next_state = MODE_GEAR3;
      end
      MODE_GEAR3: begin
        // The gear block owns menu handling while the hurricane countdown runs.
        if (power_evt)           next_state = MODE_OFF;
        else if (hurricane_done) next_state = (return_state == RET_GEAR2) ? MODE_GEAR2
                                                                          : MODE_STANDBY;
      end
      default: begin
        power_on   = 1'b0;
        next_state = MODE_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) hurricane_req <= 1'b0;
    else     hurricane_req <= (next_state == MODE_GEAR3) && (state != MODE_GEAR3);
  end

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (state != MODE_MENU || next_state != MODE_MENU || any_press)
      idle_cnt <= '0;
    else if (tick_1hz && idle_cnt != '1)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign mode_state = state;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl: vector table plus timeout/reset sequences.
module tb_hood_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_1hz;
  logic       power_btn, menu_btn, gear1_btn, gear2_btn, gear3_btn;
  logic       hurricane_avail, hurricane_done, return_state;
  logic [2:0] mode_state;
  logic       power_on, menu_active, hurricane_req;

  int num_vectors = 0;
  int num_errors  = 0;

  // Input byte order: {power, menu, gear1, gear2, gear3, avail, done, return_state}
  typedef struct {
    logic [7:0] in;
    logic [2:0] mode;
    logic       pon;
    logic       mact;
    logic       req;
  } vec_t;

  vec_t vecs[$];

  hood_mode_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .power_btn(power_btn), .menu_btn(menu_btn),
    .gear1_btn(gear1_btn), .gear2_btn(gear2_btn), .gear3_btn(gear3_btn),
    .hurricane_avail(hurricane_avail), .hurricane_done(hurricane_done),
    .return_state(return_state), .mode_state(mode_state),
    .power_on(power_on), .menu_active(menu_active), .hurricane_req(hurricane_req)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] in, input logic tk, input logic rs);
    @(negedge clk);
    {power_btn, menu_btn, gear1_btn, gear2_btn, gear3_btn,
     hurricane_avail, hurricane_done, return_state} = in;
    tick_1hz = tk;
    rst      = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] mode,
                             input logic pon, input logic mact, input logic req);
    num_vectors++;
    if ({mode_state, power_on, menu_active, hurricane_req} !== {mode, pon, mact, req}) begin
      num_errors++;
      $display("[TB] FAIL %s: got mode=%b pon=%b menu=%b req=%b, want mode=%b pon=%b menu=%b req=%b",
               name, mode_state, power_on, menu_active, hurricane_req, mode, pon, mact, req);
    end
  endtask

  function automatic void addVec(input logic [7:0] in, input logic [2:0] mode,
                                 input logic pon, input logic mact, input logic req);
    vec_t v;
    v.in = in; v.mode = mode; v.pon = pon; v.mact = mact; v.req = req;
    vecs.push_back(v);
  endfunction

  task automatic tickCheck(input string name, input logic [7:0] in, input logic [2:0] mode,
                           input logic mact);
    applyStimulus(in, 1'b1, 1'b0);
    checkOutput(name, mode, 1'b1, mact, 1'b0);
    applyStimulus(in, 1'b0, 1'b0);
  endtask

  initial begin
    // Power held through reset must not produce a press.
    applyStimulus(8'b1000_0000, 1'b0, 1'b1);
    applyStimulus(8'b1000_0000, 1'b0, 1'b1);
    checkOutput("reset_state", 3'b100, 0, 0, 0);
    applyStimulus(8'b1000_0000, 1'b0, 1'b0);
    checkOutput("held_thru_reset", 3'b100, 0, 0, 0);

`ifdef LONG_PRESS_POWER_EN
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    applyStimulus(8'b1000_0000, 1'b0, 1'b0);
    tickCheck("hold_tick1", 8'b1000_0000, 3'b100, 0);
    applyStimulus(8'b1000_0000, 1'b1, 1'b0);
    checkOutput("hold_tick2", 3'b100, 0, 0, 0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    checkOutput("short_hold_release", 3'b100, 0, 0, 0);
    applyStimulus(8'b1000_0000, 1'b0, 1'b0);
    checkOutput("press_no_toggle", 3'b100, 0, 0, 0);
    for (int i = 0; i < 2; i++) tickCheck("long_hold_early", 8'b1000_0000, 3'b100, 0);
    applyStimulus(8'b1000_0000, 1'b1, 1'b0);
    checkOutput("long_hold_on", 3'b000, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'b1000_0000, 1'b0, 1'b0);
      applyStimulus(8'b1000_0000, 1'b1, 1'b0);
      checkOutput("no_second_toggle", 3'b000, 1, 0, 0);
    end
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    applyStimulus(8'b1000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tickCheck("hold_off_early", 8'b1000_0000, 3'b000, 0);
    applyStimulus(8'b1000_0000, 1'b1, 1'b0);
    checkOutput("long_hold_off", 3'b100, 0, 0, 0);
`else
    addVec(8'b0000_0000, 3'b100, 0, 0, 0);
    addVec(8'b0100_0000, 3'b100, 0, 0, 0);  // menu ignored while off
    addVec(8'b0000_0000, 3'b100, 0, 0, 0);
    addVec(8'b1000_0000, 3'b000, 1, 0, 0);
    addVec(8'b0000_0000, 3'b000, 1, 0, 0);
    addVec(8'b0100_0000, 3'b101, 1, 1, 0);
    addVec(8'b0000_0000, 3'b101, 1, 1, 0);
    addVec(8'b0001_0000, 3'b010, 1, 0, 0);
    addVec(8'b0000_0000, 3'b010, 1, 0, 0);
    addVec(8'b0010_0000, 3'b001, 1, 0, 0);
    addVec(8'b0000_0000, 3'b001, 1, 0, 0);
    addVec(8'b0100_0000, 3'b000, 1, 0, 0);
    addVec(8'b0000_0000, 3'b000, 1, 0, 0);
    addVec(8'b0000_0011, 3'b000, 1, 0, 0);  // done outside gear3 ignored
    addVec(8'b0100_0000, 3'b101, 1, 1, 0);
    addVec(8'b0000_1000, 3'b101, 1, 1, 0);  // gear3 without avail
    addVec(8'b0000_0000, 3'b101, 1, 1, 0);
    addVec(8'b0001_0000, 3'b010, 1, 0, 0);
    addVec(8'b0000_0000, 3'b010, 1, 0, 0);
    addVec(8'b0000_1100, 3'b011, 1, 0, 1);
    addVec(8'b0000_0100, 3'b011, 1, 0, 0);
    addVec(8'b0010_0100, 3'b011, 1, 0, 0);  // gear1 ignored in gear3
    addVec(8'b0000_0100, 3'b011, 1, 0, 0);
    addVec(8'b0100_0100, 3'b011, 1, 0, 0);  // menu ignored in gear3
    addVec(8'b0000_0100, 3'b011, 1, 0, 0);
    addVec(8'b0000_0111, 3'b010, 1, 0, 0);
    addVec(8'b0000_0100, 3'b010, 1, 0, 0);
    addVec(8'b0000_1100, 3'b011, 1, 0, 1);
    addVec(8'b0000_0100, 3'b011, 1, 0, 0);
    addVec(8'b0000_0110, 3'b000, 1, 0, 0);
    addVec(8'b0000_0100, 3'b000, 1, 0, 0);
    addVec(8'b0100_0100, 3'b101, 1, 1, 0);
    addVec(8'b0000_0100, 3'b101, 1, 1, 0);
    addVec(8'b0010_0100, 3'b001, 1, 0, 0);
    addVec(8'b0000_0100, 3'b001, 1, 0, 0);
    addVec(8'b0000_1100, 3'b011, 1, 0, 1);
    addVec(8'b0000_0100, 3'b011, 1, 0, 0);
    addVec(8'b1000_0111, 3'b100, 0, 0, 0);  // power beats done
    addVec(8'b0000_0000, 3'b100, 0, 0, 0);
    addVec(8'b1000_0000, 3'b000, 1, 0, 0);
    addVec(8'b0000_0000, 3'b000, 1, 0, 0);
    addVec(8'b0100_0000, 3'b101, 1, 1, 0);
    addVec(8'b0000_0000, 3'b101, 1, 1, 0);
    addVec(8'b0110_0000, 3'b000, 1, 0, 0);  // menu beats gear1
    addVec(8'b0000_0000, 3'b000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pon, vecs[i].mact, vecs[i].req);
    end

    // Menu idle timeout fires on the tenth tick.
    applyStimulus(8'b0100_0000, 1'b0, 1'b0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tickCheck("menu_idle", 8'b0000_0000, 3'b101, 1);
    applyStimulus(8'b0000_0000, 1'b1, 1'b0);
    checkOutput("menu_timeout", 3'b000, 1, 0, 0);

    // A press after nine ticks restarts the idle count.
    applyStimulus(8'b0100_0000, 1'b0, 1'b0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(8'b0000_0000, 1'b1, 1'b0);
    applyStimulus(8'b0000_1000, 1'b0, 1'b0);
    checkOutput("restart_press", 3'b101, 1, 1, 0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tickCheck("menu_restarted", 8'b0000_0000, 3'b101, 1);
    applyStimulus(8'b0000_0000, 1'b1, 1'b0);
    checkOutput("menu_timeout2", 3'b000, 1, 0, 0);

    // Reset during gear3 forces off.
    applyStimulus(8'b0100_0000, 1'b0, 1'b0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    applyStimulus(8'b0000_1100, 1'b0, 1'b0);
    checkOutput("gear3_before_reset", 3'b011, 1, 0, 1);
    applyStimulus(8'b0000_0100, 1'b0, 1'b1);
    checkOutput("reset_in_gear3", 3'b100, 0, 0, 0);
    applyStimulus(8'b0000_0000, 1'b0, 1'b0);
    checkOutput("after_reset", 3'b100, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_errors);
    $finish;
  end

endmodule
